// File: rtl/approx_eval_pkg.sv
// Shared types and width helpers for the approximate-circuit error monitor.
package approx_eval_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // err_count must hold 2^num_in itself, hence one extra bit
   function automatic int cnt_w(input int num_in);
      return num_in + 1;
   endfunction

   // sum of up to 2^num_in errors, each below 2^out_w
   function automatic int sum_w(input int num_in, input int out_w);
      return num_in + out_w;
   endfunction

   // settle down-counter holds values 0..settle-1
   function automatic int settle_w(input int settle);
      return (settle < 2) ? 1 : $clog2(settle);
   endfunction

endpackage

// File: rtl/abs_err_calc.sv
// Combinational |a-b| and threshold compare. The larger operand is always
// the minuend, so the W-bit result cannot overflow.
module abs_err_calc #(
   parameter int          W  = 3,
   parameter int unsigned ET = 2
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_err,
   output logic         o_over
);

   assign o_err  = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
   assign o_over = (32'(o_err) > ET);

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustive error monitor: sweeps every input vector, compares the exact and
// approximate circuit responses and collects max error, nonzero-error count,
// threshold violation and first failing vector.
// Optional feature: define ERR_SUM_EN to add the sum_err accumulator output.
module approx_error_monitor
   import approx_eval_pkg::*;
#(
   parameter int          NUM_IN = 4,
   parameter int          OUT_W  = 3,
   parameter int unsigned ET     = 2,
   parameter int          SETTLE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [NUM_IN-1:0] vec_out,
   input  logic [OUT_W-1:0]  exact_in,
   input  logic [OUT_W-1:0]  approx_in,
   output logic              busy,
   output logic              done,
   output logic [OUT_W-1:0]  max_err,
   output logic [NUM_IN:0]   err_count,
   output logic              violation,
   output logic [NUM_IN-1:0] first_fail_vec
`ifdef ERR_SUM_EN
   ,
   output logic [NUM_IN+OUT_W-1:0] sum_err
`endif
);

   localparam int                CW   = cnt_w(NUM_IN);
   localparam int                SW   = settle_w(SETTLE);
   localparam logic [NUM_IN-1:0] LAST = '1;
   // state entered after start and after each non-final sample
   localparam state_t            ST_STEP = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
   localparam logic [SW-1:0]     SETTLE_LD = SW'(SETTLE - 1);

   state_t            r_state;
   logic [SW-1:0]     r_settle_cnt;
   logic [NUM_IN-1:0] r_vec;
   logic [OUT_W-1:0]  r_max;
   logic [CW-1:0]     r_cnt;
   logic              r_viol;
   logic [NUM_IN-1:0] r_ffv;
`ifdef ERR_SUM_EN
   localparam int     SUMW = sum_w(NUM_IN, OUT_W);
   logic [SUMW-1:0]   r_sum;
`endif

   logic [OUT_W-1:0]  w_err;
   logic              w_over;

   abs_err_calc #(.W(OUT_W), .ET(ET)) u_abs_err (
      .i_a    (exact_in),
      .i_b    (approx_in),
      .o_err  (w_err),
      .o_over (w_over)
   );

   // sweep sequencer and statistics; abort beats sampling on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= '0;
         r_vec        <= '0;
         r_max        <= '0;
         r_cnt        <= '0;
         r_viol       <= 1'b0;
         r_ffv        <= '0;
`ifdef ERR_SUM_EN
         r_sum        <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state      <= ST_STEP;
                  r_settle_cnt <= SETTLE_LD;
                  r_vec        <= '0;
                  r_max        <= '0;
                  r_cnt        <= '0;
                  r_viol       <= 1'b0;
                  r_ffv        <= '0;
`ifdef ERR_SUM_EN
                  r_sum        <= '0;
`endif
               end
            end
            ST_SETTLE: begin
               if (abort)
                  r_state <= ST_IDLE;
               else if (r_settle_cnt == '0)
                  r_state <= ST_SAMPLE;
               else
                  r_settle_cnt <= r_settle_cnt - 1'b1;
            end
            ST_SAMPLE: begin
               if (abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  if (w_err > r_max)
                     r_max <= w_err;
                  r_cnt <= r_cnt + CW'(w_err != '0);
                  if (w_over && !r_viol) begin
                     r_viol <= 1'b1;
                     r_ffv  <= r_vec;
                  end
`ifdef ERR_SUM_EN
                  r_sum <= r_sum + SUMW'(w_err);
`endif
                  if (r_vec == LAST) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_vec        <= r_vec + 1'b1;
                     r_state      <= ST_STEP;
                     r_settle_cnt <= SETTLE_LD;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vec_out        = r_vec;
   assign busy           = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
   assign done           = (r_state == ST_DONE);
   assign max_err        = r_max;
   assign err_count      = r_cnt;
   assign violation      = r_viol;
   assign first_fail_vec = r_ffv;
`ifdef ERR_SUM_EN
   assign sum_err        = r_sum;
`endif

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: two instances (SETTLE=0 and SETTLE=2) swept
// with the same approximate-response table, checked every cycle against a
// sweep-level model plus literal expectations for the known cases.
module tb_approx_error_monitor;
   localparam int NI = 4;
   localparam int OW = 3;
   localparam int ET = 2;

   logic clk = 1'b0;
   logic rst, start, abort;
   always #5 clk = ~clk;

   logic [NI-1:0] vec0, vec2, ffv0, ffv2;
   logic [OW-1:0] ex0, ap0, ex2, ap2, mx0, mx2;
   logic [NI:0]   cnt0, cnt2;
   logic          busy0, busy2, done0, done2, viol0, viol2;
`ifdef ERR_SUM_EN
   logic [OW+NI-1:0] sum0, sum2;
`endif

   logic [OW-1:0] lut   [16];   // approximate circuit behaviour for this sweep
   logic [OW-1:0] m_lut [16];   // table the model evaluates (captured at start)
   int errors = 0;
   int checks = 0;

   // exact circuit: |{in1,in0} - {in3,in2}|
   function automatic int exact_f(input int v);
      int a, b;
      a = v & 3;
      b = (v >> 2) & 3;
      return (a > b) ? a - b : b - a;
   endfunction

   assign ex0 = OW'(exact_f(int'(vec0)));
   assign ex2 = OW'(exact_f(int'(vec2)));
   assign ap0 = lut[vec0];
   assign ap2 = lut[vec2];

   approx_error_monitor #(.NUM_IN(NI), .OUT_W(OW), .ET(ET), .SETTLE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec0),
      .exact_in(ex0), .approx_in(ap0), .busy(busy0), .done(done0),
      .max_err(mx0), .err_count(cnt0), .violation(viol0), .first_fail_vec(ffv0)
`ifdef ERR_SUM_EN
      , .sum_err(sum0)
`endif
   );

   approx_error_monitor #(.NUM_IN(NI), .OUT_W(OW), .ET(ET), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .vec_out(vec2),
      .exact_in(ex2), .approx_in(ap2), .busy(busy2), .done(done2),
      .max_err(mx2), .err_count(cnt2), .violation(viol2), .first_fail_vec(ffv2)
`ifdef ERR_SUM_EN
      , .sum_err(sum2)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // statistics after the first n vectors of a sweep have been sampled
   function automatic void pref(input int n, output int mx, output int cnt,
                                output int viol, output int ffv, output int sm);
      int e;
      mx = 0; cnt = 0; viol = 0; ffv = 0; sm = 0;
      for (int v = 0; v < n; v++) begin
         e = exact_f(v) - int'(m_lut[v]);
         if (e < 0) e = -e;
         if (e > mx) mx = e;
         if (e != 0) cnt++;
         sm += e;
         if (e > ET && viol == 0) begin
            viol = 1;
            ffv  = v;
         end
      end
   endfunction

   function automatic int per_of(input int d);
      return (d == 0) ? 1 : 3;   // cycles per vector = SETTLE+1
   endfunction

   // sweep-level model: phase 0 idle, 1 running, 2 done; k = edges since start
   int m_phase [2];
   int m_k     [2];
   int m_n     [2];
   bit m_vknown[2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            m_phase[d]  <= 0;
            m_k[d]      <= 0;
            m_n[d]      <= 0;
            m_vknown[d] <= 1'b1;
         end
      end else begin
         if (start && m_phase[0] != 1 && m_phase[1] != 1)
            for (int v = 0; v < 16; v++) m_lut[v] <= lut[v];
         for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 1) begin
               if (abort) begin
                  m_phase[d]  <= 0;
                  m_vknown[d] <= 1'b0;
               end else begin
                  m_k[d] <= m_k[d] + 1;
                  m_n[d] <= (m_k[d] + 1) / per_of(d);
                  if (m_k[d] + 1 == 16 * per_of(d)) m_phase[d] <= 2;
               end
            end else if (start) begin
               m_phase[d]  <= 1;
               m_k[d]      <= 0;
               m_n[d]      <= 0;
               m_vknown[d] <= 1'b1;
            end
         end
      end
   end

   task automatic check_dut(input int d, input int busy, input int done, input int vec,
                            input int mx, input int cnt, input int viol, input int ffv,
                            input int sm);
      int emx, ecnt, eviol, effv, esm, evec;
      pref(m_n[d], emx, ecnt, eviol, effv, esm);
      chk($sformatf("busy%0d", d), busy, int'(m_phase[d] == 1));
      chk($sformatf("done%0d", d), done, int'(m_phase[d] == 2));
      if (m_vknown[d]) begin
         evec = (m_phase[d] == 1) ? m_k[d] / per_of(d) : (m_phase[d] == 2) ? 15 : 0;
         chk($sformatf("vec%0d", d), vec, evec);
      end
      chk($sformatf("max_err%0d", d), mx, emx);
      chk($sformatf("err_count%0d", d), cnt, ecnt);
      chk($sformatf("violation%0d", d), viol, eviol);
      chk($sformatf("first_fail%0d", d), ffv, effv);
`ifdef ERR_SUM_EN
      chk($sformatf("sum_err%0d", d), sm, esm);
`endif
   endtask

   // per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (!rst) begin
`ifdef ERR_SUM_EN
         check_dut(0, busy0, done0, vec0, mx0, cnt0, viol0, ffv0, sum0);
         check_dut(1, busy2, done2, vec2, mx2, cnt2, viol2, ffv2, sum2);
`else
         check_dut(0, busy0, done0, vec0, mx0, cnt0, viol0, ffv0, 0);
         check_dut(1, busy2, done2, vec2, mx2, cnt2, viol2, ffv2, 0);
`endif
      end
   end

   task automatic set_lut(input int mode);
      for (int v = 0; v < 16; v++)
         lut[v] = (mode == 0) ? OW'(exact_f(v)) : (mode == 1) ? '0 : OW'($urandom_range(0, 7));
   endtask

   // full sweep from IDLE/DONE; latency counted in negedges after start edge
   task automatic sweep(input int mode);
      int k;
      set_lut(mode);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_vec_cleared", vec0, 0);
      chk("start_cnt_cleared", cnt0, 0);
      chk("start_max_cleared", mx0, 0);
      k = 0;
      while (!done0 && k < 100) begin @(negedge clk); k++; end
      chk("done_latency_settle0", k, 16);
      while (!done2 && k < 200) begin @(negedge clk); k++; end
      chk("done_latency_settle2", k, 48);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_vec0(input int v);
      int k;
      k = 0;
      while (vec0 != NI'(v) && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) chk("wait_vec_timeout", int'(vec0), v);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      set_lut(1);
      for (int v = 0; v < 16; v++) m_lut[v] = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_vec", vec0, 0);
      chk("rst_cnt", cnt0, 0);
      rst = 1'b0;
      @(negedge clk);

      // identical circuits: no error at all
      sweep(0);
      chk("ident_max", mx0, 0);
      chk("ident_cnt", cnt0, 0);
      chk("ident_viol", viol0, 0);

      // approx output stuck at zero, restarted from DONE
      sweep(1);
      chk("zero_max", mx0, 3);
      chk("zero_cnt", cnt0, 12);
      chk("zero_viol", viol0, 1);
      chk("zero_ffv", ffv0, 3);
      chk("zero_max_s2", mx2, 3);
      chk("zero_cnt_s2", cnt2, 12);
      chk("zero_ffv_s2", ffv2, 3);
`ifdef ERR_SUM_EN
      chk("zero_sum", sum0, 20);
      chk("zero_sum_s2", sum2, 20);
`endif

      // random approximate tables
      repeat (3) sweep(2);

      // start while busy is ignored, then abort at vector 5
      set_lut(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec0(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_ignored", vec0, 4);
      @(negedge clk);
      chk("abort_at_vec", vec0, 5);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy0, 0);
      chk("abort_done", done0, 0);
      chk("abort_cnt_frozen", cnt0, 4);
      chk("abort_max_frozen", mx0, 3);
      repeat (3) @(negedge clk);
      chk("abort_cnt_hold", cnt0, 4);

      // asynchronous reset in the middle of a sweep
      sweep(2);
      set_lut(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec0(9);
      #2 rst = 1'b1;
      #1;
      chk("arst_vec", vec0, 0);
      chk("arst_busy", busy0, 0);
      chk("arst_cnt", cnt0, 0);
      chk("arst_max", mx0, 0);
      chk("arst_viol", viol0, 0);
      chk("arst_ffv", ffv0, 0);
      chk("arst_busy_s2", busy2, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sweep(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule
